// File: rtl/seq_pattern_if.sv
// Handshake and data bundle for seq_pattern_gen.
//   master : drives start/abort/pattern/repeat_cnt, observes the serial outputs
//   slave  : the generator itself
// Signals:
//   start      - request a transmission (honoured only while the generator is idle)
//   abort      - cancel an active transmission
//   pattern    - PAT_W-bit pattern, sent MSB first
//   repeat_cnt - number of pattern repetitions
//   seq_out    - serial data bit, 0 whenever valid=0
//   valid      - seq_out carries a pattern bit this cycle
//   busy       - transmission in progress (pattern bits or inter-pattern gap)
//   done       - one-cycle completion pulse
interface seq_pattern_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             seq_out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, repeat_cnt,
        input  seq_out, valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, repeat_cnt,
        output seq_out, valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial bit-sequence generator. Sends a captured PAT_W-bit pattern MSB first,
// one bit per clock, repeat_cnt times with GAP_LEN idle cycles between
// repetitions, then pulses done for one cycle. All outputs are registered.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset, overrides start and abort
//   bus  - seq_pattern_if slave modport (start/abort/pattern/repeat_cnt in,
//          seq_out/valid/busy/done out)
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// SHIFT | driving pattern bits, valid=1, busy=1
// GAP   | idle cycles between repetitions, valid=0, busy=1
// DONE  | single-cycle done pulse, busy=0
module seq_pattern_gen #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_LEN = 1
) (
    input  logic           clk,
    input  logic           rst,
    seq_pattern_if.slave   bus
);

    localparam int BIT_W    = $clog2(PAT_W);
    localparam int GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int GAP_LOAD = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    // Bits still to be sent in the current repetition, left-aligned so the
    // next bit is always the MSB of this register.
    logic [PAT_W-2:0] sh_q;
    logic [BIT_W-1:0] bit_q;
    logic [CNT_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_q;
    logic             seq_out_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            sh_q      <= '0;
            bit_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            seq_out_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        pat_q <= bus.pattern;
                        if (bus.repeat_cnt != '0) begin
                            state_q   <= SHIFT;
                            rep_q     <= bus.repeat_cnt;
                            bit_q     <= BIT_W'(PAT_W - 1);
                            sh_q      <= bus.pattern[PAT_W-2:0];
                            seq_out_q <= bus.pattern[PAT_W-1];
                            valid_q   <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    if (bus.abort) begin
                        state_q   <= IDLE;
                        seq_out_q <= 1'b0;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (bit_q == '0) begin
                        // Last bit of this repetition is on the line now.
                        if (rep_q == CNT_W'(1)) begin
                            state_q   <= DONE;
                            rep_q     <= '0;
                            seq_out_q <= 1'b0;
                            valid_q   <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            rep_q <= rep_q - 1'b1;
                            if (GAP_LEN > 0) begin
                                state_q   <= GAP;
                                gap_q     <= GAP_W'(GAP_LOAD);
                                seq_out_q <= 1'b0;
                                valid_q   <= 1'b0;
                            end else begin
                                // Back-to-back: reload the MSB with no bubble.
                                bit_q     <= BIT_W'(PAT_W - 1);
                                sh_q      <= pat_q[PAT_W-2:0];
                                seq_out_q <= pat_q[PAT_W-1];
                            end
                        end
                    end else begin
                        bit_q     <= bit_q - 1'b1;
                        seq_out_q <= sh_q[PAT_W-2];
                        sh_q      <= sh_q << 1;
                    end
                end

                GAP: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (gap_q == '0) begin
                        state_q   <= SHIFT;
                        bit_q     <= BIT_W'(PAT_W - 1);
                        sh_q      <= pat_q[PAT_W-2:0];
                        seq_out_q <= pat_q[PAT_W-1];
                        valid_q   <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q   <= IDLE;
                    seq_out_q <= 1'b0;
                    valid_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.seq_out = seq_out_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;

    localparam int PW = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_pattern_if #(.PAT_W(PW), .CNT_W(CW)) b1 ();
    seq_pattern_if #(.PAT_W(PW), .CNT_W(CW)) b0 ();

    seq_pattern_gen #(.PAT_W(PW), .CNT_W(CW), .GAP_LEN(1)) u_gap1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    seq_pattern_gen #(.PAT_W(PW), .CNT_W(CW), .GAP_LEN(0)) u_gap0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];   // per-cycle {valid, seq_out, busy, done}

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={v,d,b,dn}=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] obs_of(input int sel);
        if (sel == 1) return {b1.valid, b1.seq_out, b1.busy, b1.done};
        return {b0.valid, b0.seq_out, b0.busy, b0.done};
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) b1.start = v;
        else          b0.start = v;
    endtask

    task automatic set_in(input logic [PW-1:0] pat, input logic [CW-1:0] rep);
        b1.pattern = pat;  b1.repeat_cnt = rep;
        b0.pattern = pat;  b0.repeat_cnt = rep;
    endtask

    task automatic set_abort(input logic v);
        b1.abort = v;
        b0.abort = v;
    endtask

    // Reference trace built straight from the transmission rules:
    // rep copies of the pattern MSB first, gap idle-busy cycles between them,
    // then a single done cycle.
    task automatic build(input logic [PW-1:0] pat, input int rep, input int gap);
        exp_q.delete();
        for (int r = 0; r < rep; r++) begin
            for (int i = PW - 1; i >= 0; i--) exp_q.push_back({1'b1, pat[i], 1'b1, 1'b0});
            if (r < rep - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endtask

    // kill_at > 0: after checking cycle kill_at, assert abort (kind 0) or
    // rst (kind 1) for one edge; everything afterwards must be idle.
    task automatic run(input int sel, input logic [PW-1:0] pat, input int rep,
                       input int kill_at, input int kill_kind, input bit hold,
                       input bit scramble, input string tag);
        int n;
        int last;
        logic [3:0] e;
        build(pat, rep, (sel == 1) ? 1 : 0);
        n = exp_q.size();
        if (n != rep * PW + ((rep > 0) ? (rep - 1) * ((sel == 1) ? 1 : 0) : 0) + 1)
            $fatal(1, "FAIL model_len %0d", n);
        last = (kill_at > 0) ? kill_at + 2 : n + 1;
        set_in(pat, CW'(rep));
        set_abort(1'b0);
        set_start(sel, 1'b1);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            if (kill_at > 0 && c == kill_at + 1) begin
                set_abort(1'b0);
                rst = 1'b0;
            end
            if (!hold) set_start(sel, 1'b0);
            if (scramble) set_in(PW'($urandom), CW'($urandom));
            if (kill_at > 0 && c > kill_at) e = 4'b0000;
            else if (c <= n)               e = exp_q[c-1];
            else                           e = 4'b0000;
            chk(tag, obs_of(sel), e);
            if (kill_at > 0 && c == kill_at) begin
                if (kill_kind == 0) set_abort(1'b1);
                else                rst = 1'b1;
            end
        end
        if (hold) begin
            // start is still high in this idle cycle, so the next edge restarts.
            set_in(pat, CW'(rep));
            @(posedge clk); #1;
            chk({tag, "_restart"}, obs_of(sel), {1'b1, pat[PW-1], 1'b1, 1'b0});
            set_start(sel, 1'b0);
            set_abort(1'b1);
            @(posedge clk); #1;
            chk({tag, "_restart_abort"}, obs_of(sel), 4'b0000);
            set_abort(1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_start(1, 1'b0);
        set_start(0, 1'b0);
        set_abort(1'b0);
        set_in('0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gap1", obs_of(1), 4'b0000);
        chk("reset_gap0", obs_of(0), 4'b0000);
        rst = 1'b0;
        @(posedge clk); #1;

        run(1, 4'b1011, 2, 0, 0, 1'b0, 1'b0, "t1_basic");
        run(1, 4'b1011, 0, 0, 0, 1'b0, 1'b0, "t2_zero_rep");
        run(0, 4'b1011, 0, 0, 0, 1'b0, 1'b0, "t2_zero_rep_g0");
        run(0, 4'b0110, 3, 0, 0, 1'b0, 1'b0, "t3_b2b");
        run(1, 4'b1101, 2, 3, 0, 1'b0, 1'b0, "t4_abort");
        run(1, 4'b1001, 1, 0, 0, 1'b0, 1'b0, "t4_after_abort");
        run(1, 4'b1011, 2, 5, 0, 1'b0, 1'b0, "t4_abort_gap");
        run(1, 4'b1011, 2, 0, 0, 1'b1, 1'b1, "t5_hold_scramble");
        run(0, 4'b1110, 2, 0, 0, 1'b1, 1'b1, "t5_hold_scramble_g0");
        run(1, 4'b0111, 3, 2, 1, 1'b0, 1'b0, "t6_reset");
        run(1, 4'b0101, 2, 0, 0, 1'b0, 1'b0, "t6_after_reset");

        // abort in IDLE blocks start
        set_in(4'b1111, 4'd1);
        set_abort(1'b1);
        set_start(1, 1'b1);
        @(posedge clk); #1;
        set_start(1, 1'b0);
        set_abort(1'b0);
        chk("abort_blocks_start", obs_of(1), 4'b0000);
        @(posedge clk); #1;
        chk("abort_blocks_start2", obs_of(1), 4'b0000);

        run(1, 4'b1010, 15, 0, 0, 1'b0, 1'b0, "max_rep_gap1");
        run(0, 4'b0011, 15, 0, 0, 1'b0, 1'b0, "max_rep_gap0");

        for (int k = 0; k < 20; k++) begin
            int sel;
            int rep;
            int kill;
            logic [PW-1:0] pat;
            sel  = int'($urandom_range(0, 1));
            pat  = PW'($urandom);
            rep  = int'($urandom_range(0, 5));
            kill = 0;
            if (rep > 0 && $urandom_range(0, 3) == 0)
                kill = int'($urandom_range(1, rep * PW));
            run(sel, pat, rep, kill, int'($urandom_range(0, 1)), 1'b0,
                1'($urandom_range(0, 1)), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
